// File: rtl/sb_pkg.sv
// sb_pkg: shared widths, default depth and the buffered-store entry type.
package sb_pkg;
  localparam int SB_DEPTH_DEF = 4;
  localparam int SB_AW = 16;
  localparam int SB_DW = 16;
  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;
endpackage

// File: rtl/sb_fwd_match.sv
// sb_fwd_match: youngest-first address compare across valid entries, counted back from tail.
module sb_fwd_match
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEF,
  localparam int PW = $clog2(DEPTH)
) (
  input  sb_entry_t          entries [DEPTH],
  input  logic [PW-1:0]      tail,
  input  logic [PW:0]        count,
  input  logic [SB_AW-1:0]   addr,
  output logic               hit,
  output logic [SB_DW-1:0]   data
);
  // Walk from oldest (age DEPTH) to youngest (age 1) so the youngest match wins.
  always_comb begin
    hit = 1'b0;
    data = '0;
    for (int i = DEPTH; i >= 1; i--)
      if ((PW+1)'(i) <= count && entries[tail - PW'(i)].addr == addr) begin
        hit = 1'b1;
        data = entries[tail - PW'(i)].data;
      end
  end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: circular store FIFO in front of data memory; loads take the port before drains.
// Optional store-to-load forwarding is enabled by defining SB_FORWARD_EN.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             st,
  input  logic             ld,
  input  logic [SB_AW-1:0] addr,
  input  logic [SB_DW-1:0] wdata,
  output logic [SB_DW-1:0] ld_data,
  output logic             stall,
  output logic             empty,
  output logic [SB_AW-1:0] dm_addr,
  output logic             dm_re,
  output logic             dm_we,
  output logic [SB_DW-1:0] dm_wdata,
  input  logic [SB_DW-1:0] dm_rd_data
);
  localparam int PW = $clog2(DEPTH);
  sb_entry_t entries [DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0] count, count_nxt;
  logic hit, full, ld_mem, drain, push;
  assign full = count == (PW+1)'(DEPTH);
`ifdef SB_FORWARD_EN
  logic [SB_DW-1:0] fwd_data;
  sb_fwd_match #(.DEPTH(DEPTH)) u_match (
    .entries(entries),
    .tail(tail),
    .count(count),
    .addr(addr),
    .hit(hit),
    .data(fwd_data)
  );
  assign stall = st && full;
  assign ld_data = ld ? (hit ? fwd_data : dm_rd_data) : '0;
`else
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if ((PW+1)'(i) < count && entries[head + PW'(i)].addr == addr) hit = 1'b1;
  end
  // A matching load waits for the drains to push its data out to memory.
  assign stall = (st && full) || (ld && hit);
  assign ld_data = ld ? dm_rd_data : '0;
`endif
  assign ld_mem = rst_n && ld && !hit;
  assign drain = !ld_mem && count != '0;
  assign push = st && !stall;
  assign dm_re = ld_mem;
  assign dm_we = drain;
  assign dm_addr = ld_mem ? addr : drain ? entries[head].addr : '0;
  assign dm_wdata = drain ? entries[head].data : '0;
  assign count_nxt = count + (PW+1)'(push) - (PW+1)'(drain);
  always_ff @(posedge clk)
    if (push) entries[tail] <= '{addr: addr, data: wdata};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      empty <= 1'b1;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (drain) head <= head + 1'b1;
      count <= count_nxt;
      empty <= count_nxt == '0;
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: random and directed stimulus checked against a queue-based store buffer model.
module tb_store_buffer;
  import sb_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 0, rst_n = 0, st = 0, ld = 0;
  logic [15:0] addr = 0, wdata = 0, ld_data, dm_addr, dm_wdata, dm_rd_data;
  logic stall, empty, dm_re, dm_we;
  logic [15:0] mem [65536];
  logic [15:0] ref_mem [65536];
  sb_entry_t q [$];
  int n_chk = 0, n_fail = 0;
  logic [15:0] addrs [4] = '{16'h0020, 16'h0022, 16'h0024, 16'h0040};

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .st(st), .ld(ld), .addr(addr), .wdata(wdata),
    .ld_data(ld_data), .stall(stall), .empty(empty), .dm_addr(dm_addr),
    .dm_re(dm_re), .dm_we(dm_we), .dm_wdata(dm_wdata), .dm_rd_data(dm_rd_data)
  );

  assign dm_rd_data = mem[dm_addr];
  always @(posedge clk) if (dm_we) mem[dm_addr] <= dm_wdata;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One pipeline cycle: called just after a posedge, returns just after the next one.
  task automatic cyc(input logic s, input logic l, input logic [15:0] a, input logic [15:0] d,
                     output logic stl);
    logic hit = 0, e_stall, mem_ld, drain;
    logic [15:0] fd = 0, e_ld, e_addr, e_wdata;
    sb_entry_t h;
    foreach (q[i]) if (q[i].addr == a) begin hit = 1; fd = q[i].data; end
`ifdef SB_FORWARD_EN
    e_stall = s && q.size() == DEPTH;
    e_ld = hit ? fd : ref_mem[a];
`else
    e_stall = (s && q.size() == DEPTH) || (l && hit);
    e_ld = ref_mem[a];
`endif
    mem_ld = l && !hit;
    drain = !mem_ld && q.size() > 0;
    e_addr = mem_ld ? a : drain ? q[0].addr : 16'h0;
    e_wdata = drain ? q[0].data : 16'h0;
    st = s; ld = l; addr = a; wdata = d;
    @(negedge clk);
    chk("stall", stall, e_stall);
    chk("dm_re", dm_re, mem_ld);
    chk("dm_we", dm_we, drain);
    chk("dm_addr", dm_addr, e_addr);
    chk("dm_wdata", dm_wdata, e_wdata);
    chk("empty", empty, q.size() == 0);
    if (!l) chk("ld_data_idle", ld_data, 16'h0);
    else if (!e_stall) chk("ld_data", ld_data, e_ld);
    @(posedge clk);
    if (drain) begin
      h = q.pop_front();
      ref_mem[h.addr] = h.data;
    end
    if (s && !e_stall) q.push_back('{addr: a, data: d});
    stl = e_stall;
    #1;
    st = 0; ld = 0;
  endtask

  initial begin
    logic held = 0, ps = 0, pl = 0, dummy;
    logic [15:0] pa = 0, pd = 0;
    int r;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'(i * 7 + 3);
      ref_mem[i] = 16'(i * 7 + 3);
    end
    #12;
    chk("rst_empty", empty, 1);
    chk("rst_stall", stall, 0);
    chk("rst_dm_we", dm_we, 0);
    chk("rst_dm_re", dm_re, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk) #1;
    // Single store drains in the next cycle.
    cyc(1, 0, 16'h0010, 16'hBEEF, dummy);
    chk("st1_we", dm_we, 1);
    chk("st1_addr", dm_addr, 16'h0010);
    chk("st1_wdata", dm_wdata, 16'hBEEF);
    cyc(0, 0, 16'h0, 16'h0, dummy);
    chk("st1_empty", empty, 1);
    for (int i = 0; i < 5; i++) cyc(1, 0, 16'h0050 + 16'(i), 16'hA000 + 16'(i), dummy);
    repeat (2) cyc(0, 0, 16'h0, 16'h0, dummy);
    // Same-address stores then a load of that address.
    cyc(1, 0, 16'h0020, 16'h1111, dummy);
    cyc(1, 0, 16'h0020, 16'h2222, dummy);
    held = 1;
    for (int i = 0; i < 4 && held; i++) cyc(0, 1, 16'h0020, 16'h0, held);
    chk("ld20_done", held, 0);
    // Non-matching loads hold the port and block the drain.
    cyc(1, 0, 16'h0030, 16'h3333, dummy);
    repeat (3) cyc(0, 1, 16'h0040, 16'h0, dummy);
    chk("ld40_nodrain", empty, 0);
    cyc(0, 0, 16'h0, 16'h0, dummy);
    // Reset asserted while a drain is in progress.
    cyc(1, 0, 16'h0100, 16'h7777, dummy);
    ld = 1; addr = 16'h0200;
    rst_n = 0;
    #1;
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_we", dm_we, 0);
    chk("mid_rst_re", dm_re, 0);
    chk("mid_rst_stall", stall, 0);
    q.delete();
    @(negedge clk) rst_n = 1;
    ld = 0;
    @(posedge clk) #1;
    cyc(0, 1, 16'h0100, 16'h0, dummy);
    chk("rst_mem_kept", ld_data, 16'(16'h0100 * 7 + 3));
    held = 0;
    for (int n = 0; n < 600; n++) begin
      if (!held) begin
        r = $urandom_range(0, 2);
        ps = r == 1;
        pl = r == 2;
        pa = addrs[$urandom_range(0, 3)];
        pd = 16'($urandom);
      end
      cyc(ps, pl, pa, pd, held);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, number of buffered stores; power of two, 2..16.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 st  input  1  pipeline store request this cycle.
REQ-005 ld  input  1  pipeline load request this cycle; st and ld are never both high.
REQ-006 addr  input  16  load/store word address.
REQ-007 wdata  input  16  store data.
REQ-008 ld_data  output  16  load result, valid in the same cycle as ld.
REQ-009 stall  output  1  pipeline must hold the current request and re-present it next cycle.
REQ-010 empty  output  1  no buffered stores; used by halt logic.
REQ-011 dm_addr  output  16  data-memory address.
REQ-012 dm_re  output  1  data-memory read enable.
REQ-013 dm_we  output  1  data-memory write enable.
REQ-014 dm_wdata  output  16  data-memory write data.
REQ-015 dm_rd_data  input  16  data-memory read data, valid by the end of the cycle dm_re is high.

Function
REQ-016 Buffer: circular FIFO of DEPTH {addr,data} entries; head/tail pointers wrap modulo DEPTH; count 0..DEPTH.
REQ-017 The DM port is driven combinationally each cycle; dm_re and dm_we are never both high.
REQ-018 Port priority: an accepted ld that needs memory -> dm_re=1, dm_addr=addr; else, if count>0 -> drain: dm_we=1, dm_addr/dm_wdata = head entry; else dm_re=dm_we=0, dm_addr=0, dm_wdata=0.
REQ-019 A drain pops the head at the posedge ending the drain cycle.
REQ-020 Stores enqueue at the tail on posedge when st && !stall; earliest DM write of that store is in the following cycle (no write-through).
REQ-021 stall = st && count==DEPTH; a drain in that cycle frees the slot, and the store is accepted next cycle.
REQ-022 Simultaneous enqueue and drain leave count unchanged; both pointers advance.
REQ-023 Stores to equal addresses are not coalesced; each drains separately, in order.
REQ-024 ld_data = forwarded data on a forwarding hit (see Configuration), else dm_rd_data; 0 when ld is low.
REQ-025 empty = (count==0), registered with count.

Reset
REQ-026 When rst_n is low: count, head, and tail go to 0 immediately; entries are don't-care; empty=1; stall=0; dm_re=dm_we=0.
REQ-027 A reset during a drain cycle discards all buffered stores; no partial write is guaranteed.

Configuration
REQ-028 Macro SB_FORWARD_EN.
- Defined: a load whose addr matches any valid entry returns the youngest matching entry's data with no stall and dm_re=0, so a drain proceeds in that same cycle.
- Undefined: a matching load asserts stall and the drain takes the port; the stall repeats until no valid entry matches, after which the load reads DM.
- Non-matching loads behave identically in both builds.

Structure
REQ-029 Package sb_pkg holds SB_DEPTH_DEF=4, SB_AW=16, SB_DW=16, and typedef sb_entry_t {addr, data}.
REQ-030 One sub-module, sb_fwd_match, performs the youngest-first address compare across valid entries, relative to tail. It is instantiated only under SB_FORWARD_EN.

Verification
REQ-031 Reset, then st addr=0x0010 data=0xBEEF -> next cycle dm_we=1, dm_addr=0x0010, dm_wdata=0xBEEF; afterwards empty=1.
REQ-032 Five consecutive stores with ld=0 and DEPTH=4:
- the drain starts in cycle 2 after the first store, so the 5th store is accepted without stall;
- all five DM writes occur in issue order.
REQ-033 Buffer holds 0x20->0x1111 and 0x20->0x2222, then ld addr=0x20:
- with SB_FORWARD_EN: ld_data=0x2222 in the same cycle, dm_re=0;
- without it: stall for 2 cycles, then a DM read returns 0x2222.
REQ-034 Buffer full while ld to a non-matching addr=0x40 repeats every cycle:
- dm_re=1 each cycle; no drain occurs;
- a st in that window stalls until ld drops, then drains resume.
REQ-035 Assert rst_n low mid-drain with count=3 -> count=0, empty=1, dm_we=0 immediately; later loads read unmodified DM contents.
